// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: initiator side of the data-memory port.
// Latches one request per access, holds the memory strobes for WAIT_CYCLES
// cycles, captures load data and stalls the pipeline until the access
// has finished.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a request; accepts when Req_Valid and no Flush
// ACCESS | strobes held, cnt counts down to 0, then data is sampled
// RESP   | Done pulse; Load_Valid for unflushed loads; pipeline advances
module mem_stage_lsu #(
   parameter int ADDR_W      = 10,
   parameter int DATA_W      = 16,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Req_Valid,
   input  logic              Req_Write,
   input  logic [ADDR_W-1:0] Req_Addr,
   input  logic [DATA_W-1:0] Req_Wdata,
   input  logic              Flush,
   output logic              Req_Ready,
   output logic              Stall,
   output logic              Done,
   output logic              Load_Valid,
   output logic [DATA_W-1:0] Load_Data,
   output logic [ADDR_W-1:0] Mem_Address,
   output logic [DATA_W-1:0] Mem_Write_Data,
   output logic              Mem_Read,
   output logic              Mem_Write,
   input  logic [DATA_W-1:0] Mem_Read_Data
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   // Counter preload so that the strobes stay high for exactly WAIT_CYCLES cycles.
   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

   state_t            state_q;
   logic [3:0]        cnt_q;
   logic              is_wr_q;
   logic              killed_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] load_data_q;
   logic              rd_q;
   logic              wr_q;

   // Access sequencer: request capture, strobe timing, load-data capture and flush tracking.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         is_wr_q     <= 1'b0;
         killed_q    <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         load_data_q <= '0;
         rd_q        <= 1'b0;
         wr_q        <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (Req_Valid && !Flush) begin
                  addr_q   <= Req_Addr;
                  wdata_q  <= Req_Wdata;
                  is_wr_q  <= Req_Write;
                  rd_q     <= !Req_Write;
                  wr_q     <= Req_Write;
                  cnt_q    <= CNT_INIT;
                  killed_q <= 1'b0;
                  state_q  <= ACCESS;
               end
            end
            ACCESS: begin
               // A flushed load still completes on the bus; only its result is suppressed.
               if (Flush && !is_wr_q)
                  killed_q <= 1'b1;
               if (cnt_q == 4'd0) begin
                  if (!is_wr_q)
                     load_data_q <= Mem_Read_Data;
                  rd_q    <= 1'b0;
                  wr_q    <= 1'b0;
                  state_q <= RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Handshake and pipeline control decoded from state; the old request is
   // still present during RESP, so Req_Ready must stay low there.
   always_comb begin
      Req_Ready  = (state_q == IDLE);
      Stall      = ((state_q == IDLE) && Req_Valid && !Flush) || (state_q == ACCESS);
      Done       = (state_q == RESP);
      Load_Valid = (state_q == RESP) && !is_wr_q && !killed_q && !Flush;
   end

   assign Load_Data      = load_data_q;
   assign Mem_Address    = addr_q;
   assign Mem_Write_Data = wdata_q;
   assign Mem_Read       = rd_q;
   assign Mem_Write      = wr_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a small data-memory model and a
// response scoreboard (expected Load_Valid/Load_Data pushed at accept,
// popped when Done is seen).
module tb_mem_stage_lsu;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 16;
   localparam int W      = 2;

   logic              Clk;
   logic              Rst;
   logic              Req_Valid;
   logic              Req_Write;
   logic [ADDR_W-1:0] Req_Addr;
   logic [DATA_W-1:0] Req_Wdata;
   logic              Flush;
   logic              Req_Ready;
   logic              Stall;
   logic              Done;
   logic              Load_Valid;
   logic [DATA_W-1:0] Load_Data;
   logic [ADDR_W-1:0] Mem_Address;
   logic [DATA_W-1:0] Mem_Write_Data;
   logic              Mem_Read;
   logic              Mem_Write;
   logic [DATA_W-1:0] Mem_Read_Data;

   typedef struct packed {
      logic              lv;
      logic [DATA_W-1:0] data;
   } resp_t;

   resp_t sb_q[$];
   int    checks = 0;
   int    errors = 0;

   logic [DATA_W-1:0] mem     [1024];
   logic              written [1024];

   mem_stage_lsu #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(W)) dut (
      .Clk            (Clk),
      .Rst            (Rst),
      .Req_Valid      (Req_Valid),
      .Req_Write      (Req_Write),
      .Req_Addr       (Req_Addr),
      .Req_Wdata      (Req_Wdata),
      .Flush          (Flush),
      .Req_Ready      (Req_Ready),
      .Stall          (Stall),
      .Done           (Done),
      .Load_Valid     (Load_Valid),
      .Load_Data      (Load_Data),
      .Mem_Address    (Mem_Address),
      .Mem_Write_Data (Mem_Write_Data),
      .Mem_Read       (Mem_Read),
      .Mem_Write      (Mem_Write),
      .Mem_Read_Data  (Mem_Read_Data)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [DATA_W-1:0] model_rd(input logic [ADDR_W-1:0] a);
      if (written[a])
         return mem[a];
      return {6'd0, a} ^ 16'h5A00;
   endfunction

   assign Mem_Read_Data = model_rd(Mem_Address);

   always @(posedge Clk) begin
      if (Rst) begin
         for (int i = 0; i < 1024; i++) written[i] <= 1'b0;
      end else if (Mem_Write) begin
         mem[Mem_Address]     <= Mem_Write_Data;
         written[Mem_Address] <= 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle_cycle();
      @(negedge Clk);
      Req_Valid = 1'b0;
      Flush     = 1'b0;
   endtask

   // One access: cycle 0 presents the request, fc selects the cycle (1..W+1)
   // in which Flush is pulsed, 0 for none.
   task automatic access(input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input int fc);
      resp_t r;
      @(negedge Clk);
      Req_Valid = 1'b1;
      Req_Write = wr;
      Req_Addr  = a;
      Req_Wdata = d;
      Flush     = 1'b0;
      #1;
      chk("c0_ready", Req_Ready, 1);
      chk("c0_stall", Stall, 1);
      r.lv   = !wr && (fc == 0);
      r.data = wr ? Load_Data : model_rd(a);
      sb_q.push_back(r);
      for (int c = 1; c <= W + 1; c++) begin
         @(negedge Clk);
         Flush = (c == fc);
         #1;
         if (c <= W) begin
            chk("acc_rd",    Mem_Read, !wr);
            chk("acc_wr",    Mem_Write, wr);
            chk("acc_addr",  Mem_Address, a);
            chk("acc_wdata", Mem_Write_Data, d);
            chk("acc_stall", Stall, 1);
            chk("acc_done",  Done, 0);
         end else begin
            chk("resp_done",  Done, 1);
            chk("resp_rd",    Mem_Read, 0);
            chk("resp_wr",    Mem_Write, 0);
            chk("resp_stall", Stall, 0);
            chk("resp_ready", Req_Ready, 0);
            if (Done) begin
               if (sb_q.size() == 0) begin
                  chk("sb_underflow", sb_q.size(), 1);
               end else begin
                  r = sb_q.pop_front();
                  chk("resp_lv", Load_Valid, r.lv);
                  if (r.lv) chk("resp_data", Load_Data, r.data);
               end
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      Rst = 1'b1; Req_Valid = 1'b1; Req_Write = 1'b0;
      Req_Addr = '0; Req_Wdata = '0; Flush = 1'b0;

      // Reset with a request pending
      @(posedge Clk); @(posedge Clk);
      @(negedge Clk); #1;
      chk("rst_rd",     Mem_Read, 0);
      chk("rst_wr",     Mem_Write, 0);
      chk("rst_addr",   Mem_Address, 0);
      chk("rst_wdata",  Mem_Write_Data, 0);
      chk("rst_ldata",  Load_Data, 0);
      chk("rst_lv",     Load_Valid, 0);
      chk("rst_done",   Done, 0);
      chk("rst_ready",  Req_Ready, 1);
      chk("rst_stall1", Stall, 1);
      Rst = 1'b0; Req_Valid = 1'b0;
      #1;
      chk("rst_stall0", Stall, 0);

      // Store then back-to-back load of the same word
      access(1'b1, 10'd5, 16'hBEEF, 0);
      access(1'b0, 10'd5, 16'h0000, 0);
      idle_cycle(); #1;
      chk("hold_ldata", Load_Data, 16'hBEEF);
      chk("hold_lv",    Load_Valid, 0);
      chk("hold_stall", Stall, 0);

      // Flushed load still runs on the bus but reports nothing
      access(1'b0, 10'h3FF, 16'h0000, 1);
      // Flushed store is not cancelled
      access(1'b1, 10'd7, 16'h1234, 1);
      access(1'b0, 10'd7, 16'h0000, 0);
      // Flush in the response cycle suppresses Load_Valid
      access(1'b0, 10'd5, 16'h0000, W + 1);
      // Unwritten word through the model
      access(1'b0, 10'h3FF, 16'h0000, 0);
      idle_cycle();

      // Request squashed in IDLE
      @(negedge Clk);
      Req_Valid = 1'b1; Req_Write = 1'b1; Req_Addr = 10'd9; Flush = 1'b1;
      #1;
      chk("fidle_stall", Stall, 0);
      chk("fidle_ready", Req_Ready, 1);
      @(negedge Clk); #1;
      chk("fidle_rd",    Mem_Read, 0);
      chk("fidle_wr",    Mem_Write, 0);
      chk("fidle_ready2", Req_Ready, 1);
      chk("fidle_done",  Done, 0);
      Req_Valid = 1'b0; Flush = 1'b0;

      // Reset in cycle 1 of a load
      @(negedge Clk);
      Req_Valid = 1'b1; Req_Write = 1'b0; Req_Addr = 10'd5;
      @(negedge Clk); #1;
      chk("mrst_rd_on", Mem_Read, 1);
      Rst = 1'b1; Req_Valid = 1'b0;
      @(negedge Clk); #1;
      chk("mrst_rd_off", Mem_Read, 0);
      chk("mrst_done",   Done, 0);
      chk("mrst_lv",     Load_Valid, 0);
      chk("mrst_ready",  Req_Ready, 1);
      Rst = 1'b0;
      for (int i = 0; i < W + 2; i++) begin
         @(negedge Clk); #1;
         chk("mrst_done_after", Done, 0);
         chk("mrst_rd_after",   Mem_Read, 0);
         chk("mrst_ready_after", Req_Ready, 1);
      end

      chk("sb_empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
